// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: latches one command, generates SCLK and chip selects,
// strobes the shift registers and stalls SCLK at 32-bit word boundaries while TX is empty.
`timescale 1ns/1ps

module spi_xfer_ctrl #(
  parameter int CS_NUM = 4,
  parameter int DIV_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      cmd_vld_i,
  output logic                      cmd_rdy_o,
  input  logic [15:0]               cmd_len_i,
  input  logic [$clog2(CS_NUM)-1:0] cmd_cs_i,
  input  logic [DIV_W-1:0]          cmd_div_i,
  input  logic                      cmd_cpol_i,
  input  logic                      tx_data_vld_i,
  output logic                      tx_en_o,
  output logic [15:0]               tx_len_o,
  output logic                      tx_len_updata_o,
  output logic                      tx_edge_o,
  output logic                      rx_edge_o,
  output logic                      sclk_o,
  output logic [CS_NUM-1:0]         csn_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [15:0]               bit_cnt_o
);

  localparam int CS_W = $clog2(CS_NUM);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STALL, HOLD, GAP} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic [15:0]       bit_q, bit_d;
  logic [15:0]       len_q, len_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              zero_q, zero_d;

  logic [CS_NUM-1:0] csn_q, csn_d;
  logic              sclk_q, sclk_d;
  logic              tx_en_q, tx_en_d;
  logic              tx_edge_q, tx_edge_d;
  logic              rx_edge_q, rx_edge_d;
  logic              updata_q, updata_d;
  logic              done_q, done_d;
  logic [15:0]       bit_cnt_q, bit_cnt_d;

  logic half_end;
  logic last_bit;
  logic stall;
  logic active;

  assign half_end = (cnt_q == div_q);
  assign last_bit = (bit_q == (len_q - 16'd1));
  // Only interior word boundaries wait for TX data; the final bit never stalls.
  assign stall    = (bit_q[4:0] == 5'd31) && !last_bit && !tx_data_vld_i;
  assign active   = (state_q == SETUP) || (state_q == SHIFT) ||
                    (state_q == STALL) || (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    len_d   = len_q;
    cs_d    = cs_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    zero_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_vld_i) begin
          len_d   = cmd_len_i;
          cs_d    = cmd_cs_i;
          div_d   = cmd_div_i;
          cpol_d  = cmd_cpol_i;
          bit_d   = 16'd0;
          cnt_d   = '0;
          phase_d = 1'b0;
          if (cmd_len_i != 16'd0) state_d = SETUP;
          else                    zero_d  = 1'b1;
        end
      end
      SETUP: begin
        if (half_end) begin
          state_d = SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (!half_end) begin
          cnt_d = cnt_q + DIV_W'(1);
        end else begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (stall) begin
            state_d = STALL;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + 16'd1;
            if (last_bit) state_d = HOLD;
          end
        end
      end
      STALL: begin
        if (tx_data_vld_i) begin
          state_d = SHIFT;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = bit_q + 16'd1;
        end
      end
      HOLD: begin
        if (half_end) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (half_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from the current state, so they trail the sequencer by one cycle.
  always_comb begin
    for (int i = 0; i < CS_NUM; i++) begin
      csn_d[i] = !(active && (cs_q == CS_W'(i)));
    end
    tx_en_d   = active;
    sclk_d    = sclk_q;
    unique case (state_q)
      SETUP, HOLD, GAP: sclk_d = cpol_q;
      SHIFT, STALL:     sclk_d = cpol_q ^ phase_q;
      default:          sclk_d = sclk_q;
    endcase
    rx_edge_d = (state_q == SHIFT) && half_end && !phase_q;
    tx_edge_d = ((state_q == SHIFT) && half_end && phase_q && !stall) ||
                ((state_q == STALL) && tx_data_vld_i);
    updata_d  = (state_q == SETUP) && (cnt_q == '0);
    done_d    = ((state_q == GAP) && (cnt_q == '0)) || zero_q;
    bit_cnt_d = bit_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      bit_q     <= 16'd0;
      len_q     <= 16'd0;
      cs_q      <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      zero_q    <= 1'b0;
      csn_q     <= '1;
      sclk_q    <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_edge_q <= 1'b0;
      rx_edge_q <= 1'b0;
      updata_q  <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      len_q     <= len_d;
      cs_q      <= cs_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      zero_q    <= zero_d;
      csn_q     <= csn_d;
      sclk_q    <= sclk_d;
      tx_en_q   <= tx_en_d;
      tx_edge_q <= tx_edge_d;
      rx_edge_q <= rx_edge_d;
      updata_q  <= updata_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign cmd_rdy_o       = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign tx_en_o         = tx_en_q;
  assign tx_len_o        = len_q;
  assign tx_len_updata_o = updata_q;
  assign tx_edge_o       = tx_edge_q;
  assign rx_edge_o       = rx_edge_q;
  assign sclk_o          = sclk_q;
  assign csn_o           = csn_q;
  assign done_o          = done_q;
  assign bit_cnt_o       = bit_cnt_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: every output is compared each cycle against
// an event-time model of SCLK toggles, chip-select window and strobes.
`timescale 1ns/1ps

module tb_spi_xfer_ctrl;

  localparam int CS_NUM = 4;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cmd_vld = 1'b0;
  logic              cmd_rdy;
  logic [15:0]       cmd_len = '0;
  logic [1:0]        cmd_cs = '0;
  logic [DIV_W-1:0]  cmd_div = '0;
  logic              cmd_cpol = 1'b0;
  logic              tx_vld = 1'b1;
  logic              tx_en;
  logic [15:0]       tx_len;
  logic              tx_len_upd;
  logic              tx_edge;
  logic              rx_edge;
  logic              sclk;
  logic [CS_NUM-1:0] csn;
  logic              busy;
  logic              done;
  logic [15:0]       bit_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int acc_cyc;
  int obs_done;
  int end_off;
  int csn_end_off;

  int nxt_len;
  int nxt_div;
  int nxt_cs;
  bit nxt_cpol;

  spi_xfer_ctrl #(.CS_NUM(CS_NUM), .DIV_W(DIV_W)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_vld_i(cmd_vld), .cmd_rdy_o(cmd_rdy), .cmd_len_i(cmd_len), .cmd_cs_i(cmd_cs),
    .cmd_div_i(cmd_div), .cmd_cpol_i(cmd_cpol), .tx_data_vld_i(tx_vld),
    .tx_en_o(tx_en), .tx_len_o(tx_len), .tx_len_updata_o(tx_len_upd),
    .tx_edge_o(tx_edge), .rx_edge_o(rx_edge), .sclk_o(sclk), .csn_o(csn),
    .busy_o(busy), .done_o(done), .bit_cnt_o(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one command. vld_on: first clock edge (relative to accept) at which TX data is present.
  // abort_at > 0 stops after that cycle offset; hold_next presents nxt_* right after accept.
  task automatic applyStimulus(input int len, input int div, input int cs, input bit cpol,
                               input int vld_on, input int abort_at, input bit hold_next);
    int h;
    int tog[$];
    int shift;
    int x;
    int s;
    int xlast;
    int csn_end;
    int t_end;
    int waits;
    int ntog;
    int ebit;
    bit erx;
    bit etx;
    bit act;
    bit ebusy;
    logic sclk_before;
    logic [CS_NUM-1:0] ecsn;
    logic [27:0] expv;
    logic [27:0] obsv;

    h = div + 1;
    cmd_len  = 16'(len);
    cmd_div  = DIV_W'(div);
    cmd_cs   = 2'(cs);
    cmd_cpol = cpol;
    cmd_vld  = 1'b1;
    tx_vld   = (0 >= vld_on);
    obs_done = -1;

    waits = 0;
    while (cmd_rdy !== 1'b1 && waits < 2000) begin
      @(posedge clk); #1;
      waits++;
    end
    if (cmd_rdy !== 1'b1) begin
      checkOutput("accept_timeout", 64'(cmd_rdy), 64'(1));
      cmd_vld = 1'b0;
      return;
    end
    sclk_before = sclk;
    tx_vld = (1 >= vld_on);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (hold_next) begin
      cmd_len  = 16'(nxt_len);
      cmd_div  = DIV_W'(nxt_div);
      cmd_cs   = 2'(nxt_cs);
      cmd_cpol = nxt_cpol;
      cmd_vld  = 1'b1;
    end else begin
      cmd_vld = 1'b0;
    end
    checkOutput("busy_after_accept", 64'(busy), 64'(len != 0));

    if (len == 0) begin
      for (int t = 1; t <= 2; t++) begin
        @(posedge clk); #1;
        checkOutput($sformatf("len0 t=%0d", t), 64'({done, csn, busy, tx_en, tx_len_upd, sclk}),
                    64'({(t == 1), {CS_NUM{1'b1}}, 1'b0, 1'b0, 1'b0, sclk_before}));
        if (done === 1'b1 && obs_done < 0) obs_done = t;
      end
      end_off = 2;
      return;
    end

    // Nominal toggle of sclk j sits at 1+(j+2)h; word-boundary stalls push later toggles out.
    shift = 0;
    for (int j = 0; j < 2 * len; j++) begin
      x = 1 + (j + 2) * h + shift;
      if ((j % 2) == 1 && ((j / 2) % 32) == 31 && (j / 2) < len - 1) begin
        s = (x - 1 >= vld_on) ? x - 1 : vld_on;
        shift += s - (x - 1);
        x = s + 1;
      end
      tog.push_back(x);
    end
    xlast   = tog[tog.size() - 1];
    csn_end = xlast + h;
    t_end   = xlast + 2 * h - 1;
    csn_end_off = csn_end;

    for (int t = 1; t <= t_end; t++) begin
      @(posedge clk); #1;
      tx_vld = (t + 1 >= vld_on);
      ntog = 0; ebit = 0; erx = 1'b0; etx = 1'b0;
      for (int j = 0; j < tog.size(); j++) begin
        if (tog[j] <= t) begin
          ntog++;
          if ((j % 2) == 1) ebit++;
        end
        if (tog[j] - 1 == t) begin
          if ((j % 2) == 1) etx = 1'b1;
          else              erx = 1'b1;
        end
      end
      act   = (t < csn_end);
      ebusy = (t <= xlast + 2 * h - 2);
      ecsn  = act ? ~(CS_NUM'(1) << cs) : {CS_NUM{1'b1}};
      expv  = {ecsn, cpol ^ ((ntog % 2) == 1), act, erx, etx, (t == csn_end), (t == 1),
               ebusy, !ebusy, 16'(ebit)};
      obsv  = {csn, sclk, tx_en, rx_edge, tx_edge, done, tx_len_upd, busy, cmd_rdy, bit_cnt};
      checkOutput($sformatf("xfer len=%0d n=%0d t=%0d", len, div, t), 64'(obsv), 64'(expv));
      if (t == 1) checkOutput("tx_len", 64'(tx_len), 64'(len));
      if (done === 1'b1 && obs_done < 0) obs_done = t;
      if (t == abort_at) return;
    end
    end_off = t_end;
  endtask

  initial begin
    int acc1;
    int end1;
    int csnend1;
    int len;
    int div;
    int cs;
    int vo;
    bit cpol;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_values",
                64'({cmd_rdy, csn, sclk, tx_en, tx_edge, rx_edge, tx_len_upd, done, busy, tx_len, bit_cnt}),
                64'({1'b1, {CS_NUM{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic transfer len=8 N=1 cs=2");
    applyStimulus(8, 1, 2, 1'b0, 0, 0, 1'b0);
    checkOutput("basic_done_latency", 64'(obs_done), 64'(37));

    $display("[TB] cpol=1 len=4 N=0");
    applyStimulus(4, 0, 1, 1'b1, 0, 0, 1'b0);
    checkOutput("cpol_done_latency", 64'(obs_done), 64'(1 + 1 * (2 + 2 * 4)));

    $display("[TB] word stall len=40 N=0");
    applyStimulus(40, 0, 3, 1'b0, 75, 0, 1'b0);
    checkOutput("stall_done_latency", 64'(obs_done), 64'(1 + (2 + 2 * 40) + 10));

    $display("[TB] zero-length command");
    applyStimulus(0, 2, 0, 1'b0, 0, 0, 1'b0);
    checkOutput("len0_done_latency", 64'(obs_done), 64'(1));

    $display("[TB] reset in the middle of bit 5");
    applyStimulus(16, 1, 1, 1'b0, 0, 24, 1'b0);
    checkOutput("pre_reset_bitcnt", 64'(bit_cnt), 64'(5));
    rstn = 1'b0;
    #2;
    checkOutput("async_reset",
                64'({cmd_rdy, csn, sclk, tx_en, tx_edge, rx_edge, tx_len_upd, done, busy, tx_len, bit_cnt}),
                64'({1'b1, {CS_NUM{1'b1}}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    checkOutput("no_done_after_reset", 64'(done), 64'(0));
    applyStimulus(12, 0, 0, 1'b1, 0, 0, 1'b0);

    $display("[TB] back-to-back commands");
    nxt_len = 16; nxt_div = 1; nxt_cs = 3; nxt_cpol = 1'b0;
    applyStimulus(8, 1, 1, 1'b0, 0, 0, 1'b1);
    acc1 = acc_cyc; end1 = end_off; csnend1 = csn_end_off;
    applyStimulus(16, 1, 3, 1'b0, 0, 0, 1'b0);
    checkOutput("b2b_accept_spacing", 64'(acc_cyc - acc1), 64'(end1 + 1));
    checkOutput("b2b_csn_gap", 64'((acc_cyc + 1) - (acc1 + csnend1) >= 2), 64'(1));

    $display("[TB] randomized transfers");
    for (int k = 0; k < 8; k++) begin
      len  = $urandom_range(1, 72);
      div  = $urandom_range(0, 3);
      cs   = $urandom_range(0, CS_NUM - 1);
      cpol = 1'($urandom_range(0, 1));
      vo   = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 400);
      applyStimulus(len, div, cs, cpol, vo, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
